// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encodings and widths for the D/E/F sequencers
package fsm_seq_pkg;

    localparam int P_STATE_W     = 3;
    localparam int P_DEF_DWELL_W = 8;

    typedef enum logic [P_STATE_W-1:0] {
        p_s0 = 3'b000,
        p_s1 = 3'b001,
        p_s2 = 3'b010,
        p_s3 = 3'b011,
        p_s4 = 3'b100
    } state_t;

    // Phase outputs {D, E, F} for a given state; D covers both S1 and S4.
    function automatic logic [2:0] phase_outs(input state_t s);
        logic [2:0] v;
        v = 3'b000;
        case (s)
            p_s1, p_s4: v = 3'b100;
            p_s2:       v = 3'b010;
            p_s3:       v = 3'b001;
            default:    v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fsm_dwell_sequencer_if.sv
// rtl/fsm_dwell_sequencer_if.sv - control/status bundle of one sequencer channel
interface fsm_dwell_sequencer_if
    import fsm_seq_pkg::*;
#(
    parameter int P_DWELL_W = P_DEF_DWELL_W
) ();

    logic                 i_Start;
    logic                 i_Abort;
    logic                 i_A;
    logic                 i_B;
    logic                 i_C;
    logic [P_DWELL_W-1:0] i_DwellD;
    logic [P_DWELL_W-1:0] i_DwellE;
    logic [P_DWELL_W-1:0] i_TimeoutF;
    logic                 o_D;
    logic                 o_E;
    logic                 o_F;
    logic                 o_Busy;
    logic                 o_Done;
    logic                 o_Timeout;
    logic [P_STATE_W-1:0] o_State;

    modport master (
        output i_Start, i_Abort, i_A, i_B, i_C, i_DwellD, i_DwellE, i_TimeoutF,
        input  o_D, o_E, o_F, o_Busy, o_Done, o_Timeout, o_State
    );

    modport slave (
        input  i_Start, i_Abort, i_A, i_B, i_C, i_DwellD, i_DwellE, i_TimeoutF,
        output o_D, o_E, o_F, o_Busy, o_Done, o_Timeout, o_State
    );

endinterface

// File: rtl/fsm_dwell_counter.sv
// rtl/fsm_dwell_counter.sv - loadable down-counter with zero flag
module fsm_dwell_counter #(
    parameter int P_DWELL_W = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Load,
    input  logic [P_DWELL_W-1:0] i_LoadVal,
    input  logic                 i_En,
    output logic [P_DWELL_W-1:0] o_Value,
    output logic                 o_Zero
);

    logic [P_DWELL_W-1:0] r_count;

    // Load has priority over counting; the caller keeps i_En low at zero.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_count <= '0;
        end else if (i_Load) begin
            r_count <= i_LoadVal;
        end else if (i_En) begin
            r_count <= r_count - {{(P_DWELL_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_Value = r_count;
    assign o_Zero  = (r_count == '0);

endmodule

// File: rtl/fsm_dwell_sequencer.sv
// rtl/fsm_dwell_sequencer.sv - five-state D/E/F sequencer with per-phase dwell and B-wait timeout
module fsm_dwell_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int P_DWELL_W = P_DEF_DWELL_W
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    fsm_dwell_sequencer_if.slave        s_if
);

    state_t               r_state;
    logic                 r_to_en;
    logic                 r_d;
    logic                 r_e;
    logic                 r_f;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout;

    state_t               w_next;
    logic                 w_load;
    logic [P_DWELL_W-1:0] w_load_val;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_to_en_next;
    logic [P_DWELL_W-1:0] w_cnt_value;
    logic                 w_cnt_zero;
    logic                 w_cnt_en;
    logic [P_DWELL_W-1:0] w_load_d;
    logic [P_DWELL_W-1:0] w_load_e;
    logic [P_DWELL_W-1:0] w_load_f;
    logic [2:0]           w_phase;

    localparam logic [P_DWELL_W-1:0] L_ONE = {{(P_DWELL_W-1){1'b0}}, 1'b1};

    // A dwell of N loads N-1 so the state is visible for N cycles; 0 behaves as 1.
    assign w_load_d = (s_if.i_DwellD   == '0) ? '0 : s_if.i_DwellD   - L_ONE;
    assign w_load_e = (s_if.i_DwellE   == '0) ? '0 : s_if.i_DwellE   - L_ONE;
    assign w_load_f = (s_if.i_TimeoutF == '0) ? '0 : s_if.i_TimeoutF - L_ONE;

    // Counter parks at zero so a disabled timeout never wraps.
    assign w_cnt_en = (w_cnt_value != '0);

    fsm_dwell_counter #(
        .P_DWELL_W (P_DWELL_W)
    ) u_counter (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Load    (w_load),
        .i_LoadVal (w_load_val),
        .i_En      (w_cnt_en),
        .o_Value   (w_cnt_value),
        .o_Zero    (w_cnt_zero)
    );

    // Next-state, counter load and status-pulse decode; abort overrides everything.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_to_en_next = r_to_en;

        case (r_state)
            p_s0: begin
                if (s_if.i_Start) begin
                    w_next     = s_if.i_A ? p_s4 : p_s1;
                    w_load     = 1'b1;
                    w_load_val = w_load_d;
                end
            end
            p_s1: begin
                if (w_cnt_zero) begin
                    w_next     = p_s2;
                    w_load     = 1'b1;
                    w_load_val = w_load_e;
                end
            end
            p_s2: begin
                if (w_cnt_zero) begin
                    w_next       = p_s3;
                    w_load       = 1'b1;
                    w_load_val   = w_load_f;
                    w_to_en_next = (s_if.i_TimeoutF != '0);
                end
            end
            p_s3: begin
                if (s_if.i_B) begin
                    if (s_if.i_C) begin
                        w_next     = p_s4;
                        w_load     = 1'b1;
                        w_load_val = w_load_d;
                    end else begin
                        w_next = p_s0;
                        w_done = 1'b1;
                    end
                end else if (r_to_en && w_cnt_zero) begin
                    w_next    = p_s0;
                    w_timeout = 1'b1;
                end
            end
            p_s4: begin
                if (w_cnt_zero) begin
                    w_next = p_s0;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = p_s0;
            end
        endcase

        if (s_if.i_Abort) begin
            w_next    = p_s0;
            w_load    = 1'b0;
            w_done    = 1'b0;
            w_timeout = 1'b0;
        end
    end

    assign w_phase = phase_outs(w_next);

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= p_s0;
            r_to_en   <= 1'b0;
            r_d       <= 1'b0;
            r_e       <= 1'b0;
            r_f       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_to_en   <= w_to_en_next;
            r_d       <= w_phase[2];
            r_e       <= w_phase[1];
            r_f       <= w_phase[0];
            r_busy    <= (w_next != p_s0);
            r_done    <= w_done;
            r_timeout <= w_timeout;
        end
    end

    assign s_if.o_D       = r_d;
    assign s_if.o_E       = r_e;
    assign s_if.o_F       = r_f;
    assign s_if.o_Busy    = r_busy;
    assign s_if.o_Done    = r_done;
    assign s_if.o_Timeout = r_timeout;
    assign s_if.o_State   = r_state;

endmodule
